stat_update_scheduler: RTL
==========================

Name: stat_update_scheduler

Overview:
- Sequences all changes to the pet's five stat registers (food, sleep, fun, happy, health) through one update channel.
- Generates the 1 Hz timebase and per-stat decay events.
- Latches user action pulses (feed, rest, play, heal).
- Round-robin arbitrates pending up/down events into a single valid/ready command stream consumed by the stat datapath. Sits between the debounced button/sensor logic and the stat registers.

Parameters:
- CLK_FREQ, 50000000, clock cycles per second tick (>=2)
- FOOD_PERIOD, 30, seconds between food decay events (>=1)
- SLEEP_PERIOD, 31, seconds between sleep decay events (>=1)
- FUN_PERIOD, 24, seconds between fun decay events (>=1)
- HAPPY_PERIOD, 22, seconds between happy decay events (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- feed_req  in  1  one-cycle pulse: request food +1
- rest_req  in  1  one-cycle pulse: request sleep +1
- play_req  in  1  one-cycle pulse: request fun +1
- heal_req  in  1  one-cycle pulse: request health +1
- pause  in  1  level: freeze timebase and decay timers
- upd_valid  out  1  update command valid
- upd_ready  in  1  datapath accepts command
- upd_sel  out  3  stat index: 0 food, 1 sleep, 2 fun, 3 happy, 4 health
- upd_up  out  1  1 = increment, 0 = decrement
- sec_tick  out  1  one-cycle pulse per elapsed second
- lost_evt  out  1  sticky: an event was dropped
- evt_count  out  8  issued-command counter (optional feature)

Behaviour:
- Reset values: all outputs 0; prescaler, decay timers and pending flags 0; RR pointer 0; FSM IDLE. rst clears everything immediately, including an in-flight command (upd_valid drops asynchronously).
- Prescaler: counts 0..CLK_FREQ-1. sec_tick=1 for the cycle in which count==CLK_FREQ-1, then wraps to 0. Holds value while pause=1; no tick while paused.
- Decay timers: stats 0-3 each have a seconds counter. On sec_tick it increments. When it would reach PERIOD it wraps to 0 and sets down_pend[i]. Health (4) has no decay timer.
- Pending flags: up_pend[i] is set by the matching *_req (happy has no up source; up_pend[3] stays 0). down_pend[i] is set by its timer. Flags are registered: a request sampled at edge k is visible from cycle k.
- Lost events: a set event arriving while the same flag is already pending is dropped and sets lost_evt. lost_evt clears only on rst.
- Same-cycle set and clear: if a flag is set in the same cycle it is cleared by an accept, the flag stays 1 (new event kept).
- FSM states: IDLE, ISSUE, GAP.
- IDLE: if any flag is pending, pick the first stat with a pending flag searching from the RR pointer upward with wrap 4->0. Load upd_sel. Within that stat, up has priority over down. Go to ISSUE; upd_valid=1 from the next cycle.
- ISSUE: upd_valid=1. upd_sel and upd_up are held stable until upd_valid&&upd_ready. On handshake, clear the served flag, set RR pointer = sel+1 (4 wraps to 0), go to GAP.
- GAP: one cycle with upd_valid=0, so the datapath value settles before the next command. Then go to IDLE.
- Throughput: at most one command per 3 cycles. Latency from request pulse to upd_valid = 2 cycles when idle.
- pause does not stall arbitration or user requests; it only freezes time.

Optional Feature:
- Macro: STAT_UPD_EVT_CNT_EN.
- Defined: evt_count increments on every accepted handshake, saturating at 255; cleared by rst.
- Undefined: evt_count is tied to 8'd0 and no counter logic is synthesised.

Decomposition:
- Package stat_sched_pkg holds:
  - stat index constants STAT_FOOD..STAT_HEALTH and NUM_STATS=5
  - direction constants DIR_UP/DIR_DOWN
  - FSM state encoding (IDLE/ISSUE/GAP, 2 bits)
- Sub-module decay_timer (parameter PERIOD; ports clk, rst, tick_en, expire): instantiated four times.
- Prescaler, pending flags and arbiter stay in the top module.

Test Plan:
- Reset: assert rst mid-ISSUE -> upd_valid=0 the same cycle, all pending cleared, lost_evt=0; after release, no command without a stimulus.
- Decay: CLK_FREQ=4, FOOD_PERIOD=2, others 100, upd_ready=1 -> first down command sel=0, up=0 after the 2nd sec_tick (cycle 8 edge + 2); repeats every 8 cycles.
- Round-robin: feed_req, rest_req and heal_req in the same cycle, ready=1 -> commands sel 0, 1, 4 in order, 3 cycles apart; a following play_req issues sel 2 next.
- Backpressure: feed_req with upd_ready=0 for 10 cycles -> upd_valid, sel=0, up=1 held stable 10 cycles; a second feed_req meanwhile sets lost_evt=1.
- Priority: food up and down pending together -> up issued first, then down.
- pause: pause=1 for 20 cycles with CLK_FREQ=4 -> no sec_tick and timers frozen; feed_req still produces a command; timing resumes from the held count. With STAT_UPD_EVT_CNT_EN, 300 accepts -> evt_count=255.

Source files
------------

// File: rtl/stat_sched_pkg.sv
// Shared constants for the pet stat update scheduler: stat indices,
// update directions and the arbiter FSM encoding.
package stat_sched_pkg;

    localparam int NUM_STATS = 5;

    localparam logic [2:0] STAT_FOOD   = 3'd0;
    localparam logic [2:0] STAT_SLEEP  = 3'd1;
    localparam logic [2:0] STAT_FUN    = 3'd2;
    localparam logic [2:0] STAT_HAPPY  = 3'd3;
    localparam logic [2:0] STAT_HEALTH = 3'd4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

    // Round-robin successor: health wraps back to food.
    function automatic logic [2:0] next_stat(input logic [2:0] idx);
        return (idx == STAT_HEALTH) ? STAT_FOOD : idx + 3'd1;
    endfunction

endpackage

// File: rtl/decay_timer.sv
// Seconds counter for one stat: pulses expire on the tick that completes
// PERIOD seconds, then restarts from zero.
module decay_timer #(
    parameter int PERIOD = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    output logic expire
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = tick_en && (cnt_q == CW'(PERIOD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (tick_en)
            cnt_d = expire ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stat_update_scheduler.sv
// Serialises user actions and timed decay into one valid/ready stat update
// stream. Define STAT_UPD_EVT_CNT_EN to build the issued-command counter.
module stat_update_scheduler
    import stat_sched_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int FOOD_PERIOD  = 30,
    parameter int SLEEP_PERIOD = 31,
    parameter int FUN_PERIOD   = 24,
    parameter int HAPPY_PERIOD = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       feed_req,
    input  logic       rest_req,
    input  logic       play_req,
    input  logic       heal_req,
    input  logic       pause,
    output logic       upd_valid,
    input  logic       upd_ready,
    output logic [2:0] upd_sel,
    output logic       upd_up,
    output logic       sec_tick,
    output logic       lost_evt,
    output logic [7:0] evt_count
);

    localparam int PW = $clog2(CLK_FREQ);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick     = !pause && (presc_q == PW'(CLK_FREQ - 1));
    assign sec_tick = tick;

    always_comb begin
        presc_d = presc_q;
        if (!pause)
            presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end

    logic [3:0] expire;

    decay_timer #(.PERIOD(FOOD_PERIOD)) u_food_timer (
        .clk(clk), .rst(rst), .tick_en(tick), .expire(expire[0])
    );
    decay_timer #(.PERIOD(SLEEP_PERIOD)) u_sleep_timer (
        .clk(clk), .rst(rst), .tick_en(tick), .expire(expire[1])
    );
    decay_timer #(.PERIOD(FUN_PERIOD)) u_fun_timer (
        .clk(clk), .rst(rst), .tick_en(tick), .expire(expire[2])
    );
    decay_timer #(.PERIOD(HAPPY_PERIOD)) u_happy_timer (
        .clk(clk), .rst(rst), .tick_en(tick), .expire(expire[3])
    );

    sched_state_e state_q;
    logic         upd_valid_q;
    logic [2:0]   upd_sel_q;
    logic         upd_up_q;
    logic [2:0]   rr_q;
    logic         hs;

    assign hs        = upd_valid_q && upd_ready;
    assign upd_valid = upd_valid_q;
    assign upd_sel   = upd_sel_q;
    assign upd_up    = upd_up_q;

    logic [NUM_STATS-1:0] up_pend_q, up_pend_d, dn_pend_q, dn_pend_d;
    logic [NUM_STATS-1:0] up_set, dn_set, up_clr, dn_clr;
    logic                 lost_q, lost_d;

    // Happy has no user source and health has no decay timer.
    assign up_set = {heal_req, 1'b0, play_req, rest_req, feed_req};
    assign dn_set = {1'b0, expire};

    always_comb begin
        up_clr = '0;
        dn_clr = '0;
        if (hs) begin
            if (upd_up_q == DIR_UP) up_clr[upd_sel_q] = 1'b1;
            else                    dn_clr[upd_sel_q] = 1'b1;
        end
    end

    // A new event landing on the cycle its flag is served replaces it and is not lost.
    always_comb begin
        up_pend_d = (up_pend_q & ~up_clr) | up_set;
        dn_pend_d = (dn_pend_q & ~dn_clr) | dn_set;
        lost_d    = lost_q
                  | (|(up_set & up_pend_q & ~up_clr))
                  | (|(dn_set & dn_pend_q & ~dn_clr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_pend_q <= '0;
            dn_pend_q <= '0;
            lost_q    <= 1'b0;
        end else begin
            up_pend_q <= up_pend_d;
            dn_pend_q <= dn_pend_d;
            lost_q    <= lost_d;
        end
    end

    assign lost_evt = lost_q;

    logic [NUM_STATS-1:0] any_pend;
    logic [2:0]           pick, scan;
    logic                 found;

    assign any_pend = up_pend_q | dn_pend_q;

    always_comb begin
        pick  = rr_q;
        scan  = rr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_STATS; k++) begin
            if (!found && any_pend[scan]) begin
                pick  = scan;
                found = 1'b1;
            end
            scan = next_stat(scan);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            upd_valid_q <= 1'b0;
            upd_sel_q   <= STAT_FOOD;
            upd_up_q    <= DIR_DOWN;
            rr_q        <= STAT_FOOD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        upd_sel_q   <= pick;
                        upd_up_q    <= up_pend_q[pick] ? DIR_UP : DIR_DOWN;
                        upd_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        upd_valid_q <= 1'b0;
                        rr_q        <= next_stat(upd_sel_q);
                        state_q     <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    upd_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

`ifdef STAT_UPD_EVT_CNT_EN
    logic [7:0] evt_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          evt_cnt_q <= 8'd0;
        else if (hs && evt_cnt_q != 8'hFF) evt_cnt_q <= evt_cnt_q + 8'd1;
    end

    assign evt_count = evt_cnt_q;
`else
    assign evt_count = 8'd0;
`endif

endmodule
